// File: rtl/bank_manager_pkg.sv
// bank_manager_pkg: shared constants, command layout and tuning/waveform
// tables for the bank_manager tone-generator bank.
// Optional feature macro: BANK_MANAGER_SINE_EN (sine voices instead of sawtooth).
package bank_manager_pkg;

    localparam int unsigned SAMPLE_W  = 24;
    localparam int unsigned PHASE_W   = 32;
    localparam int unsigned NOTE_W    = 7;
    localparam int unsigned NUM_NOTES = 128;

    typedef enum logic [1:0] {
        CMD_IDLE     = 2'b00,
        CMD_NOTE_ON  = 2'b01,
        CMD_NOTE_OFF = 2'b10,
        CMD_ALL_OFF  = 2'b11
    } cmd_e;

    typedef struct packed {
        cmd_e              op;
        logic [6:0]        rsvd;
        logic [NOTE_W-1:0] note;
    } cmd_t;

    // Per-note phase increment for a given output rate; note 69 (A4) = 440 Hz,
    // fractional part dropped (note 69 at 96 kHz gives 19685266).
    function automatic logic [NUM_NOTES-1:0][PHASE_W-1:0] tune_table(input int unsigned sample_rate);
        logic [NUM_NOTES-1:0][PHASE_W-1:0] t;
        real f;
        real w;
        t = '0;
        for (int unsigned n = 0; n < NUM_NOTES; n++) begin
            f    = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
            w    = $floor(f * 4294967296.0 / real'(sample_rate));
            t[n] = PHASE_W'(longint'(w));
        end
        return t;
    endfunction

`ifdef BANK_MANAGER_SINE_EN
    localparam logic [SAMPLE_W-1:0] SINE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    // Quarter-wave table: entry k = round((2^23-1) * sin(2*pi*k/1024)).
    function automatic logic [255:0][SAMPLE_W-1:0] sine_table();
        logic [255:0][SAMPLE_W-1:0] t;
        real a;
        t = '0;
        for (int unsigned k = 0; k < 256; k++) begin
            a    = 8388607.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
            t[k] = SAMPLE_W'(longint'(a));
        end
        return t;
    endfunction

    localparam logic [255:0][SAMPLE_W-1:0] SINE_TABLE = sine_table();

    // Full-wave sine from the quarter table: mirror on odd quadrants, negate on the upper half.
    function automatic logic signed [SAMPLE_W-1:0] sine_lookup(input logic [PHASE_W-1:0] phase);
        logic [1:0]          quad;
        logic [8:0]          k;
        logic [SAMPLE_W-1:0] mag;
        quad = phase[PHASE_W-1 -: 2];
        k    = quad[0] ? (9'd256 - {1'b0, phase[PHASE_W-3 -: 8]}) : {1'b0, phase[PHASE_W-3 -: 8]};
        mag  = k[8] ? SINE_MAX : SINE_TABLE[k[7:0]];
        return quad[1] ? -signed'(mag) : signed'(mag);
    endfunction
`endif

endpackage

// File: rtl/nco_voice.sv
// nco_voice: one phase-accumulator voice of the bank.
// Ports: clk, reset (sync, active-high), clk_en (sample advance),
//        start/stop (allocate/free strobes), load_note/load_tune (captured on start),
//        active (voice busy), note (held note), sample_c (signed voice sample).
// Macro BANK_MANAGER_SINE_EN: sine output through a registered lookup (+1 cycle).
module nco_voice
    import bank_manager_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       start,
    input  logic                       stop,
    input  logic [NOTE_W-1:0]          load_note,
    input  logic [PHASE_W-1:0]         load_tune,
    output logic                       active,
    output logic [NOTE_W-1:0]          note,
    output logic signed [SAMPLE_W-1:0] sample_c
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tune;

    // Voice state; commands act regardless of clk_en, phase only advances on clk_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            phase  <= '0;
            tune   <= '0;
            note   <= '0;
        end else if (stop) begin
            active <= 1'b0;
            phase  <= '0;
        end else if (start) begin
            active <= 1'b1;
            phase  <= '0;
            tune   <= load_tune;
            note   <= load_note;
        end else if (clk_en && active) begin
            phase  <= phase + tune;
        end
    end

`ifdef BANK_MANAGER_SINE_EN
    logic signed [SAMPLE_W-1:0] sine_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sine_q <= '0;
        end else if (clk_en) begin
            sine_q <= active ? sine_lookup(phase) : '0;
        end
    end

    assign sample_c = sine_q;
`else
    // Sawtooth: top bits of the phase read as a signed sample.
    assign sample_c = active ? signed'(phase[PHASE_W-1 -: SAMPLE_W]) : '0;
`endif

endmodule

// File: rtl/bank_manager.sv
// bank_manager: polyphonic tone-generator bank. Decodes note commands,
// allocates them to NUM_GEN nco_voice instances and outputs their
// headroom-scaled, saturated sum.
// Ports: clk, reset (sync, active-high), clk_en (sample advance),
//        i_data (16-bit command word), o_signal (signed 24-bit mix),
//        o_active (per-voice busy flags).
// Macro BANK_MANAGER_SINE_EN: sine voices (one extra cycle of o_signal latency).
module bank_manager
    import bank_manager_pkg::*;
#(
    parameter int unsigned NUM_GEN     = 4,
    parameter int unsigned SAMPLE_RATE = 96000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic [15:0]                i_data,
    output logic signed [SAMPLE_W-1:0] o_signal,
    output logic [NUM_GEN-1:0]         o_active
);

    localparam int unsigned SHIFT = $clog2(NUM_GEN);
    localparam int unsigned ACC_W = SAMPLE_W + SHIFT;
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(SHIFT+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(SHIFT+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
    localparam logic [NUM_NOTES-1:0][PHASE_W-1:0] TUNE_TABLE = tune_table(SAMPLE_RATE);

    cmd_t                       cmd;
    logic                       unused_rsvd;
    logic [PHASE_W-1:0]         tune_word;
    logic [NUM_GEN-1:0]         active;
    logic [NUM_GEN-1:0]         hit;
    logic [NUM_GEN-1:0]         free;
    logic [NUM_GEN-1:0]         first_free;
    logic [NUM_GEN-1:0]         start;
    logic [NUM_GEN-1:0]         stop;
    logic [NOTE_W-1:0]          vnote   [NUM_GEN];
    logic signed [SAMPLE_W-1:0] vsample [NUM_GEN];
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] mix_c;

    assign cmd         = cmd_t'(i_data);
    assign unused_rsvd = ^cmd.rsvd;
    assign tune_word   = TUNE_TABLE[cmd.note];
    assign o_active    = active;

    // Command decode and allocation; first_free isolates the lowest set bit of free.
    always_comb begin
        hit        = '0;
        start      = '0;
        stop       = '0;
        free       = ~active;
        first_free = free & (~free + NUM_GEN'(1));
        for (int k = 0; k < NUM_GEN; k++) begin
            hit[k] = active[k] && (vnote[k] == cmd.note);
        end
        case (cmd.op)
            CMD_NOTE_ON:  if (hit == '0) start = first_free;
            CMD_NOTE_OFF: stop = hit;
            CMD_ALL_OFF:  stop = '1;
            default:      ;
        endcase
    end

    for (genvar k = 0; k < NUM_GEN; k++) begin : g_voice
        nco_voice u_voice (
            .clk       (clk),
            .reset     (reset),
            .clk_en    (clk_en),
            .start     (start[k]),
            .stop      (stop[k]),
            .load_note (cmd.note),
            .load_tune (tune_word),
            .active    (active[k]),
            .note      (vnote[k]),
            .sample_c  (vsample[k])
        );
    end

    // Mixer: pre-scaled samples summed with headroom, then clamped as a guard.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_GEN; k++) begin
            acc = acc + ACC_W'(vsample[k] >>> SHIFT);
        end
        if (acc > SAT_HI) begin
            mix_c = SAMPLE_W'(SAT_HI);
        end else if (acc < SAT_LO) begin
            mix_c = SAMPLE_W'(SAT_LO);
        end else begin
            mix_c = SAMPLE_W'(acc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_signal <= '0;
        end else if (clk_en) begin
            o_signal <= mix_c;
        end
    end

endmodule

// File: tb/tb_bank_manager.sv
// tb_bank_manager: directed, table-driven check of bank_manager with
// NUM_GEN = 4 and SAMPLE_RATE = 96000 (note 69 tuning word = 19685266).
module tb_bank_manager;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic [15:0]        i_data;
    logic signed [23:0] o_signal;
    logic [3:0]         o_active;

    typedef struct {
        bit          rst;
        bit          en;
        logic [15:0] data;
        logic [3:0]  act;
        bit          chk_sig;
        int          sig;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    bank_manager #(.NUM_GEN(4), .SAMPLE_RATE(96000)) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .i_data   (i_data),
        .o_signal (o_signal),
        .o_active (o_active)
    );

    always #5 clk = ~clk;

    task automatic add(input bit rst, input bit en, input logic [15:0] data,
                       input logic [3:0] act, input bit chk_sig, input int sig);
        vec_t v;
        v.rst = rst; v.en = en; v.data = data; v.act = act; v.chk_sig = chk_sig; v.sig = sig;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then check outputs 1 time unit after the edge.
    task automatic apply(input vec_t v, input string name);
        logic signed [23:0] want;
        reset  = v.rst;
        clk_en = v.en;
        i_data = v.data;
        @(posedge clk);
        #1;
        n_vec++;
        if (o_active !== v.act) begin
            n_bad++;
            $display("FAIL %s o_active: got %b want %b", name, o_active, v.act);
        end
        want = 24'(v.sig);
        if (v.chk_sig && (o_signal !== want)) begin
            n_bad++;
            $display("FAIL %s o_signal: got %0d want %0d", name, o_signal, want);
        end
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        i_data = 16'h0000;

        // Reset, then idle with clk_en high.
        add(1, 0, 16'h0000, 4'b0000, 1, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 16'h0000, 4'b0000, 1, 0);
        // Note on 69 with clk_en held: 0, 0, then (k*19685266 >> 8) >>> 2.
        add(0, 1, 16'h4045, 4'b0001, 1, 0);
        add(0, 1, 16'h0000, 4'b0001, 1, 0);
        add(0, 1, 16'h0000, 4'b0001, 1, 19223);
        add(0, 1, 16'h0000, 4'b0001, 1, 38447);
        add(0, 1, 16'h0000, 4'b0001, 1, 57671);
        // Stall holds phase and output.
        add(0, 0, 16'h0000, 4'b0001, 1, 57671);
        add(0, 0, 16'h0000, 4'b0001, 1, 57671);
        add(0, 1, 16'h0000, 4'b0001, 1, 76895);
        // Note off on a clk_en edge still emits the current sample, then 0.
        add(0, 1, 16'h8045, 4'b0000, 1, 96119);
        add(0, 1, 16'h0000, 4'b0000, 1, 0);
        add(0, 0, 16'hC000, 4'b0000, 1, 0);
        // Allocation order, pool full, free and reuse.
        add(0, 0, 16'h403C, 4'b0001, 1, 0);
        add(0, 0, 16'h4040, 4'b0011, 1, 0);
        add(0, 0, 16'h4043, 4'b0111, 1, 0);
        add(0, 0, 16'h4045, 4'b1111, 1, 0);
        add(0, 0, 16'h4048, 4'b1111, 1, 0);
        add(0, 0, 16'h8040, 4'b1101, 1, 0);
        add(0, 0, 16'h4048, 4'b1111, 1, 0);
        add(0, 0, 16'h8048, 4'b1101, 1, 0);
        add(0, 0, 16'hC000, 4'b0000, 1, 0);
        // Note on while stalled: allocated, output frozen until clk_en returns.
        add(0, 0, 16'h4045, 4'b0001, 1, 0);
        add(0, 0, 16'h0000, 4'b0001, 1, 0);
        add(0, 1, 16'h0000, 4'b0001, 1, 0);
        add(0, 1, 16'h0000, 4'b0001, 1, 19223);
        // Duplicate note on is ignored; next note takes voice 1.
        add(0, 0, 16'h4045, 4'b0001, 1, 19223);
        add(0, 0, 16'h403C, 4'b0011, 1, 19223);
        // All off, then output clears on the next clk_en edge.
        add(0, 0, 16'hC000, 4'b0000, 1, 19223);
        add(0, 1, 16'h0000, 4'b0000, 1, 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-playback with three voices sounding; the command in the reset cycle is lost.
        begin
            vec_t v;
            v.rst = 0; v.en = 0; v.chk_sig = 1; v.sig = 0;
            v.data = 16'h403C; v.act = 4'b0001; apply(v, "rst_seq_on60");
            v.data = 16'h4040; v.act = 4'b0011; apply(v, "rst_seq_on64");
            v.data = 16'h4045; v.act = 4'b0111; apply(v, "rst_seq_on69");
            v.en = 1; v.data = 16'h0000; v.chk_sig = 0;
            for (int i = 0; i < 5; i++) apply(v, $sformatf("rst_seq_play%0d", i));
            n_vec++;
            if (o_signal == 24'sd0) begin
                n_bad++;
                $display("FAIL rst_seq_playing o_signal: got %0d want nonzero", o_signal);
            end
            v.rst = 1; v.data = 16'h4045; v.act = 4'b0000; v.chk_sig = 1; v.sig = 0;
            apply(v, "rst_seq_reset");
            v.rst = 0; v.data = 16'h0000;
            apply(v, "rst_seq_after");
            v.data = 16'h4045; v.act = 4'b0001; apply(v, "rst_seq_reon");
            v.data = 16'h0000; apply(v, "rst_seq_s0");
            v.sig = 19223; apply(v, "rst_seq_s1");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
